// File: rtl/s38584_pkg.sv
// Shared definitions for the s38584 read-select block: mode encodings, the
// pipeline stage entry and the saturating error-count helper.
package s38584_pkg;

  localparam logic [1:0] RD_DEC = 2'd0;
  localparam logic [1:0] RD_BYP = 2'd1;
  localparam logic [1:0] RD_OR  = 2'd2;
  localparam logic [1:0] RD_RSV = 2'd3;

  // Widest channel word a stage can carry; narrower DW uses the low bits.
  localparam int DW_MAX = 64;

  typedef struct packed {
    logic              valid;
    logic [DW_MAX-1:0] data;
    logic              hit;
    logic              err;
  } rd_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/s38584_rdsel_dec.sv
// Combinational request decode: address/tag match, channel select, bypass
// and OR-of-enabled-channels, producing one stage entry.
module s38584_rdsel_dec
  import s38584_pkg::*;
#(
  parameter int NCH  = 16,
  parameter int DW   = 1,
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic               i_valid,
  input  logic [AW-1:0]      i_addr,
  input  logic [1:0]         i_mode,
  input  logic [NCH*DW-1:0]  i_chan_d,
  input  logic [NCH-1:0]     i_chan_en,
  input  logic [DW-1:0]      i_bypass_d,
  input  logic [DW-1:0]      i_dflt_d,
  output rd_entry_t          o_ent
);

  localparam int IW = $clog2(NCH);
  localparam int TW = AW - IW;
  localparam logic [TW-1:0] TAG = TW'(BASE);

  logic [IW-1:0] w_idx;
  logic          w_tag_hit;
  logic [DW-1:0] w_chan   [NCH];
  logic [DW-1:0] w_masked [NCH];
  logic [DW-1:0] w_or_all;

  assign w_idx     = i_addr[IW-1:0];
  assign w_tag_hit = (i_addr[AW-1:IW] == TAG);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_chan[gi]   = i_chan_d[gi*DW +: DW];
      assign w_masked[gi] = i_chan_en[gi] ? w_chan[gi] : '0;
    end
  endgenerate

  always_comb begin
    w_or_all = '0;
    for (int i = 0; i < NCH; i++) begin
      w_or_all = w_or_all | w_masked[i];
    end
  end

  // The reserved mode falls through to the decoded read.
  always_comb begin
    o_ent       = '0;
    o_ent.valid = i_valid;
    case (i_mode)
      RD_BYP: o_ent.data[DW-1:0] = i_bypass_d;
      RD_OR:  o_ent.data[DW-1:0] = w_or_all;
      default: begin
        if (!w_tag_hit) begin
          o_ent.data[DW-1:0] = i_dflt_d;
        end else if (!i_chan_en[w_idx]) begin
          o_ent.data[DW-1:0] = i_dflt_d;
          o_ent.hit          = 1'b1;
          o_ent.err          = 1'b1;
        end else begin
          o_ent.data[DW-1:0] = w_chan[w_idx];
          o_ent.hit          = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/s38584_rdsel.sv
// Read-select top: decodes a request in its acceptance cycle, carries it
// through 1+PIPE elastic stages and keeps a saturating error count.
module s38584_rdsel
  import s38584_pkg::*;
#(
  parameter int NCH  = 16,
  parameter int DW   = 1,
  parameter int AW   = 8,
  parameter int BASE = 0,
  parameter int PIPE = 0
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_addr,
  input  logic [1:0]         req_mode,
  input  logic [NCH*DW-1:0]  chan_d,
  input  logic [NCH-1:0]     chan_en,
  input  logic [DW-1:0]      bypass_d,
  input  logic [DW-1:0]      dflt_d,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_hit,
  output logic               rsp_err,
  output logic [7:0]         err_cnt
);

  localparam int NS = 1 + PIPE;

  rd_entry_t   w_dec;
  rd_entry_t   w_up  [NS];
  rd_entry_t   r_stg [NS];
  logic [NS-1:0] w_acc;
  logic [NS-1:0] w_load;
  logic        r_rdy_en;
  logic [7:0]  r_err_cnt;
  logic        w_rsp_fire;

  s38584_rdsel_dec #(
    .NCH  (NCH),
    .DW   (DW),
    .AW   (AW),
    .BASE (BASE)
  ) u_dec (
    .i_valid    (req_valid),
    .i_addr     (req_addr),
    .i_mode     (req_mode),
    .i_chan_d   (chan_d),
    .i_chan_en  (chan_en),
    .i_bypass_d (bypass_d),
    .i_dflt_d   (dflt_d),
    .o_ent      (w_dec)
  );

  // A stage can take a new entry when it is empty or its entry moves on.
  always_comb begin
    w_acc         = '0;
    w_acc[NS-1]   = !r_stg[NS-1].valid || rsp_ready;
    for (int s = NS - 2; s >= 0; s--) begin
      w_acc[s] = !r_stg[s].valid || w_acc[s+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_up[gi]   = w_dec;
        assign w_load[gi] = w_acc[gi] && r_rdy_en;
      end else begin : g_body
        assign w_up[gi]   = r_stg[gi-1];
        assign w_load[gi] = w_acc[gi];
      end
    end
  endgenerate

  assign w_rsp_fire = r_stg[NS-1].valid && rsp_ready;

  // Payload only moves with a valid entry, so a bubble leaves stage data untouched.
  always_ff @(posedge CK) begin
    if (RST) begin
      for (int s = 0; s < NS; s++) begin
        r_stg[s] <= '0;
      end
      r_rdy_en  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      for (int s = 0; s < NS; s++) begin
        if (w_load[s]) begin
          r_stg[s].valid <= w_up[s].valid;
          if (w_up[s].valid) begin
            r_stg[s].data <= w_up[s].data;
            r_stg[s].hit  <= w_up[s].hit;
            r_stg[s].err  <= w_up[s].err;
          end
        end
      end
      if (w_rsp_fire && r_stg[NS-1].err) begin
        r_err_cnt <= sat_inc8(r_err_cnt);
      end
    end
  end

  assign req_ready = w_acc[0] && r_rdy_en;
  assign rsp_valid = r_stg[NS-1].valid;
  assign rsp_data  = r_stg[NS-1].data[DW-1:0];
  assign rsp_hit   = r_stg[NS-1].hit;
  assign rsp_err   = r_stg[NS-1].err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_s38584_rdsel.sv
// Directed bench for s38584_rdsel: a PIPE=0 instance (a_*) for decode, modes,
// throughput and error counting, and a PIPE=1 instance (b_*) for backpressure and reset.
module tb_s38584_rdsel;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic RST;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_hit, a_rsp_err;
  logic [7:0]  a_req_addr, a_err_cnt;
  logic [1:0]  a_req_mode;
  logic [15:0] a_chan_d, a_chan_en;
  logic [0:0]  a_bypass_d, a_dflt_d, a_rsp_data;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_hit, b_rsp_err;
  logic [7:0]  b_req_addr, b_err_cnt;
  logic [1:0]  b_req_mode;
  logic [15:0] b_chan_d, b_chan_en;
  logic [0:0]  b_bypass_d, b_dflt_d, b_rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  s38584_rdsel #(.NCH(16), .DW(1), .AW(8), .BASE(0), .PIPE(0)) u_dut0 (
    .CK(CK), .RST(RST),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr), .req_mode(a_req_mode),
    .chan_d(a_chan_d), .chan_en(a_chan_en), .bypass_d(a_bypass_d), .dflt_d(a_dflt_d),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_hit(a_rsp_hit), .rsp_err(a_rsp_err), .err_cnt(a_err_cnt)
  );

  s38584_rdsel #(.NCH(16), .DW(1), .AW(8), .BASE(0), .PIPE(1)) u_dut1 (
    .CK(CK), .RST(RST),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr), .req_mode(b_req_mode),
    .chan_d(b_chan_d), .chan_en(b_chan_en), .bypass_d(b_bypass_d), .dflt_d(b_dflt_d),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_hit(b_rsp_hit), .rsp_err(b_rsp_err), .err_cnt(b_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  // One PIPE=0 transaction; inputs are scrambled right after acceptance.
  task automatic req0(input string tag, input logic [7:0] addr, input logic [1:0] mode,
                      input logic ed, input logic eh, input logic ee);
    logic [15:0] sd, se;
    logic [0:0]  sb, sf;
    tick();
    a_req_valid = 1'b1;
    a_req_addr  = addr;
    a_req_mode  = mode;
    mid();
    chk({tag, "_rdy"}, a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    sd = a_chan_d; se = a_chan_en; sb = a_bypass_d; sf = a_dflt_d;
    a_chan_d = ~sd; a_chan_en = ~se; a_bypass_d = ~sb; a_dflt_d = ~sf;
    mid();
    chk({tag, "_vld"}, a_rsp_valid, 1);
    chk({tag, "_data"}, a_rsp_data, ed);
    chk({tag, "_hit"}, a_rsp_hit, eh);
    chk({tag, "_err"}, a_rsp_err, ee);
    $display("txn %s addr=%h mode=%0d data=%0d hit=%0d err=%0d", tag, addr, mode,
             a_rsp_data, a_rsp_hit, a_rsp_err);
    a_chan_d = sd; a_chan_en = se; a_bypass_d = sb; a_dflt_d = sf;
  endtask

  logic [7:0] tp_addr [4];
  logic       tp_exp  [4];

  initial begin
    tp_addr[0] = 8'h00; tp_addr[1] = 8'h02; tp_addr[2] = 8'h01; tp_addr[3] = 8'h05;
    tp_exp[0]  = 1'b1;  tp_exp[1]  = 1'b0;  tp_exp[2]  = 1'b1;  tp_exp[3]  = 1'b0;

    RST = 1'b1;
    a_req_valid = 0; a_req_addr = 0; a_req_mode = 0; a_chan_d = 0; a_chan_en = 0;
    a_bypass_d = 0; a_dflt_d = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_addr = 0; b_req_mode = 0; b_chan_d = 0; b_chan_en = 0;
    b_bypass_d = 0; b_dflt_d = 0; b_rsp_ready = 0;

    repeat (3) tick();
    mid();
    chk("rst_a_vld", a_rsp_valid, 0);
    chk("rst_a_data", a_rsp_data, 0);
    chk("rst_a_hit", a_rsp_hit, 0);
    chk("rst_a_err", a_rsp_err, 0);
    chk("rst_a_cnt", a_err_cnt, 0);
    chk("rst_a_rdy", a_req_ready, 0);
    chk("rst_b_vld", b_rsp_valid, 0);
    chk("rst_b_rdy", b_req_ready, 0);

    tick();
    RST = 1'b0;
    tick();
    mid();
    chk("rdy_after_rst_a", a_req_ready, 1);
    chk("rdy_after_rst_b", b_req_ready, 1);

    // Decode, miss, disabled channel, reserved mode, bypass, OR.
    a_chan_d = 16'hA5C3; a_chan_en = 16'hFFFF; a_dflt_d = 1'b1; a_bypass_d = 1'b0;
    req0("dec5",   8'h05, 2'd0, 1'b0, 1'b1, 1'b0);
    req0("dec0",   8'h00, 2'd0, 1'b1, 1'b1, 1'b0);
    req0("dec6",   8'h06, 2'd0, 1'b1, 1'b1, 1'b0);
    req0("miss13", 8'h13, 2'd0, 1'b1, 1'b0, 1'b0);
    a_chan_en = 16'hFFF7;
    req0("dis3",   8'h03, 2'd0, 1'b1, 1'b1, 1'b1);
    tick(); mid();
    chk("errcnt_1", a_err_cnt, 1);
    a_chan_en = 16'hFFFF;
    req0("rsv0",   8'h00, 2'd3, 1'b1, 1'b1, 1'b0);
    req0("byp0",   8'h00, 2'd1, 1'b0, 1'b0, 1'b0);
    a_bypass_d = 1'b1;
    req0("byp1",   8'h13, 2'd1, 1'b1, 1'b0, 1'b0);
    req0("or_all", 8'h00, 2'd2, 1'b1, 1'b0, 1'b0);
    a_chan_en = 16'h0000;
    req0("or_none", 8'h05, 2'd2, 1'b0, 1'b0, 1'b0);
    a_chan_en = 16'h0010;
    req0("or4_lo", 8'h00, 2'd2, 1'b0, 1'b0, 1'b0);
    a_chan_d = 16'h0010;
    req0("or4_hi", 8'h00, 2'd2, 1'b1, 1'b0, 1'b0);
    tick(); mid();
    chk("errcnt_keep", a_err_cnt, 1);

    // Back-to-back with rsp_ready high: one transaction per cycle.
    a_chan_d = 16'hA5C3; a_chan_en = 16'hFFFF; a_req_mode = 2'd0;
    tick();
    a_req_valid = 1'b1; a_req_addr = tp_addr[0];
    mid();
    chk("tp_rdy0", a_req_ready, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      a_req_addr = tp_addr[k];
      mid();
      chk("tp_rdy", a_req_ready, 1);
      chk("tp_vld", a_rsp_valid, 1);
      chk("tp_data", a_rsp_data, tp_exp[k-1]);
      $display("txn tp%0d data=%0d", k - 1, a_rsp_data);
    end
    tick();
    a_req_valid = 1'b0;
    mid();
    chk("tp_vld3", a_rsp_valid, 1);
    chk("tp_data3", a_rsp_data, tp_exp[3]);
    tick(); mid();
    chk("tp_drain", a_rsp_valid, 0);

    // 300 error responses on top of the earlier one.
    a_chan_en = 16'hFFF7; a_req_addr = 8'h03; a_req_mode = 2'd0;
    tick();
    a_req_valid = 1'b1;
    repeat (200) tick();
    mid();
    chk("errcnt_200", a_err_cnt, 200);
    repeat (100) tick();
    a_req_valid = 1'b0;
    tick(); tick(); mid();
    chk("errcnt_sat", a_err_cnt, 255);
    $display("txn sat err_cnt=%0d", a_err_cnt);

    // PIPE=1 backpressure: two accepted, third stalls, in-order drain.
    b_chan_d = 16'hA5C3; b_chan_en = 16'hFFFF; b_req_mode = 2'd0; b_rsp_ready = 1'b0;
    tick();
    b_req_valid = 1'b1; b_req_addr = 8'h00;
    mid();
    chk("bp_rdy_a", b_req_ready, 1);
    chk("bp_vld_a", b_rsp_valid, 0);
    tick();
    b_req_addr = 8'h02;
    mid();
    chk("bp_rdy_b", b_req_ready, 1);
    chk("bp_lat", b_rsp_valid, 0);
    tick();
    b_req_addr = 8'h01;
    mid();
    chk("bp_rdy_c", b_req_ready, 0);
    chk("bp_vld", b_rsp_valid, 1);
    chk("bp_data_a", b_rsp_data, 1);
    tick(); mid();
    chk("bp_hold_rdy", b_req_ready, 0);
    chk("bp_hold_vld", b_rsp_valid, 1);
    chk("bp_hold_data", b_rsp_data, 1);
    chk("bp_hold_hit", b_rsp_hit, 1);
    tick();
    b_rsp_ready = 1'b1;
    mid();
    chk("bp_rdy_comb", b_req_ready, 1);
    chk("bp_out_a", b_rsp_data, 1);
    $display("txn bp A data=%0d", b_rsp_data);
    tick();
    b_req_valid = 1'b0;
    mid();
    chk("bp_vld_b", b_rsp_valid, 1);
    chk("bp_out_b", b_rsp_data, 0);
    $display("txn bp B data=%0d", b_rsp_data);
    tick(); mid();
    chk("bp_vld_c", b_rsp_valid, 1);
    chk("bp_out_c", b_rsp_data, 1);
    $display("txn bp C data=%0d", b_rsp_data);
    tick(); mid();
    chk("bp_drain", b_rsp_valid, 0);

    // Reset with two entries in flight.
    b_rsp_ready = 1'b0;
    tick();
    b_req_valid = 1'b1; b_req_addr = 8'h00;
    tick();
    b_req_addr = 8'h02;
    tick();
    b_req_valid = 1'b0;
    mid();
    chk("fl_vld", b_rsp_valid, 1);
    tick();
    RST = 1'b1; b_rsp_ready = 1'b1;
    tick();
    RST = 1'b0;
    mid();
    chk("fl_rst_vld", b_rsp_valid, 0);
    chk("fl_rst_rdy", b_req_ready, 0);
    chk("fl_rst_data", b_rsp_data, 0);
    chk("fl_rst_cnt", a_err_cnt, 0);
    tick(); mid();
    chk("fl_rdy", b_req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); mid();
      chk("fl_no_stale", b_rsp_valid, 0);
    end
    $display("txn flush done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
